// File: rtl/pc_lut_sequencer.sv
// Program-counter sequencer with a 16-entry jump-target table loaded over a
// valid/ready stream at boot, then sequencing the fetch PC (increment/branch/stall/halt).
module pc_lut_sequencer #(
    parameter int PC_WIDTH = 12,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [PC_WIDTH-1:0] cfg_data,
    input  logic                start,
    input  logic                branch_taken,
    input  logic [3:0]          branch_index,
    input  logic                stall,
    input  logic                halt_req,
    output logic [PC_WIDTH-1:0] pc,
    output logic                lut_loaded,
    output logic                running,
    output logic                halted
);

    localparam logic [1:0] ST_LOAD = 2'd0;
    localparam logic [1:0] ST_IDLE = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_HALT = 2'd3;

    localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);

    logic [1:0]          state_reg, state_next;
    logic [PC_WIDTH-1:0] pc_reg, pc_next;
    logic [3:0]          cnt_reg;
    logic                loaded_reg;
    logic [PC_WIDTH-1:0] entry_reg [16];
    logic [15:0]         entry_we;
    logic                cfg_write;

    assign cfg_ready = (state_reg == ST_LOAD);
    assign cfg_write = cfg_valid && cfg_ready;

    // One-hot write enable per table entry, selected by the load counter.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_entry_we
            assign entry_we[gi] = cfg_write && (cnt_reg == 4'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < 16; i++) begin
            if (reset) begin
                entry_reg[i] <= '0;
            end else if (entry_we[i]) begin
                entry_reg[i] <= cfg_data;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        case (state_reg)
            ST_LOAD: begin
                if (cfg_write && (cnt_reg == 4'd15)) begin
                    state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                pc_next = RESET_PC;
                if (start) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                // A stalled branch is dropped; the fetch stage re-presents it.
                if (halt_req) begin
                    state_next = ST_HALT;
                end else if (stall) begin
                    pc_next = pc_reg;
                end else if (branch_taken) begin
                    pc_next = entry_reg[branch_index];
                end else begin
                    pc_next = pc_reg + PC_ONE;
                end
            end
            ST_HALT: begin
                if (start) begin
                    state_next = ST_RUN;
                    pc_next    = RESET_PC;
                end
            end
            default: begin
                state_next = ST_LOAD;
                pc_next    = RESET_PC;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= ST_LOAD;
            pc_reg     <= RESET_PC;
            cnt_reg    <= 4'd0;
            loaded_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            if (cfg_write) begin
                cnt_reg <= cnt_reg + 4'd1;
                if (cnt_reg == 4'd15) begin
                    loaded_reg <= 1'b1;
                end
            end
        end
    end

    assign pc         = pc_reg;
    assign lut_loaded = loaded_reg;
    assign running    = (state_reg == ST_RUN);
    assign halted     = (state_reg == ST_HALT);

endmodule

// File: tb/tb_pc_lut_sequencer.sv
// Directed bench for pc_lut_sequencer with RESET_PC=0xFFE so the PC wrap is
// exercised right after start.
module tb_pc_lut_sequencer;

    localparam int PC_WIDTH = 12;
    localparam logic [11:0] RST_PC = 12'hFFE;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [11:0] cfg_data;
    logic        start;
    logic        branch_taken;
    logic [3:0]  branch_index;
    logic        stall;
    logic        halt_req;
    logic [11:0] pc;
    logic        lut_loaded;
    logic        running;
    logic        halted;

    int checks = 0;
    int errors = 0;

    pc_lut_sequencer #(
        .PC_WIDTH(PC_WIDTH),
        .RESET_PC(RST_PC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_data(cfg_data),
        .start(start),
        .branch_taken(branch_taken),
        .branch_index(branch_index),
        .stall(stall),
        .halt_req(halt_req),
        .pc(pc),
        .lut_loaded(lut_loaded),
        .running(running),
        .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] boot_word(input int i);
        if (i == 7) return 12'h2A0;
        return 12'h100 + 12'(i);
    endfunction

    task automatic do_branch(input logic [3:0] idx);
        branch_taken = 1'b1;
        branch_index = idx;
        step();
        branch_taken = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        cfg_valid = 1'b1;
        cfg_data = 12'hABC;
        step();
        reset = 1'b0;
        start = 1'b0;
        cfg_valid = 1'b0;
        checks++; if (pc !== RST_PC) begin errors++; $display("FAIL reset_pc got %h exp %h", pc, RST_PC); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready got %b exp 1", cfg_ready); end
        checks++; if (lut_loaded !== 1'b0) begin errors++; $display("FAIL reset_lut_loaded got %b exp 0", lut_loaded); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running got %b exp 0", running); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b exp 0", halted); end
        $display("reset: pc=%h cfg_ready=%b lut_loaded=%b", pc, cfg_ready, lut_loaded);
    endtask

    task automatic test_load_gaps();
        int accepted = 0;
        for (int i = 0; i < 16; i++) begin
            if (i == 3) begin
                cfg_valid = 1'b0;
                start = 1'b1;
                step();
                start = 1'b0;
                checks++; if (running !== 1'b0) begin errors++; $display("FAIL start_in_load_running got %b exp 0", running); end
                checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL start_in_load_cfg_ready got %b exp 1", cfg_ready); end
            end
            cfg_valid = 1'b1;
            cfg_data = boot_word(i);
            if (i == 15) begin
                checks++; if (lut_loaded !== 1'b0) begin errors++; $display("FAIL early_lut_loaded got %b exp 0", lut_loaded); end
            end
            if (cfg_ready === 1'b1) accepted++;
            step();
            $display("load: word %0d data=%h", i, cfg_data);
            if (i == 5) begin
                cfg_valid = 1'b0;
                step();
                step();
            end
        end
        cfg_valid = 1'b0;
        checks++; if (accepted !== 16) begin errors++; $display("FAIL load_accepted got %0d exp 16", accepted); end
        checks++; if (lut_loaded !== 1'b1) begin errors++; $display("FAIL lut_loaded got %b exp 1", lut_loaded); end
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL post_load_cfg_ready got %b exp 0", cfg_ready); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL post_load_running got %b exp 0", running); end
        cfg_valid = 1'b1;
        cfg_data = 12'h555;
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL word17_ready got %b exp 0", cfg_ready); end
        step();
        cfg_valid = 1'b0;
        checks++; if (pc !== RST_PC) begin errors++; $display("FAIL idle_pc got %h exp %h", pc, RST_PC); end
    endtask

    task automatic test_sequential_wrap();
        logic [11:0] exp_pc [5];
        exp_pc = '{12'hFFF, 12'h000, 12'h001, 12'h002, 12'h003};
        start = 1'b1;
        step();
        start = 1'b0;
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL start_running got %b exp 1", running); end
        checks++; if (pc !== RST_PC) begin errors++; $display("FAIL start_pc got %h exp %h", pc, RST_PC); end
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (pc !== exp_pc[i]) begin errors++; $display("FAIL seq_pc_%0d got %h exp %h", i, pc, exp_pc[i]); end
            $display("seq: pc=%h", pc);
        end
    endtask

    task automatic test_branch();
        do_branch(4'd7);
        checks++; if (pc !== 12'h2A0) begin errors++; $display("FAIL branch7 got %h exp 2a0", pc); end
        step();
        checks++; if (pc !== 12'h2A1) begin errors++; $display("FAIL branch7_inc got %h exp 2a1", pc); end
        do_branch(4'd3);
        checks++; if (pc !== 12'h103) begin errors++; $display("FAIL branch3 got %h exp 103", pc); end
        do_branch(4'd0);
        checks++; if (pc !== 12'h100) begin errors++; $display("FAIL branch0 got %h exp 100", pc); end
        do_branch(4'd15);
        checks++; if (pc !== 12'h10F) begin errors++; $display("FAIL branch15 got %h exp 10f", pc); end
        step();
        checks++; if (pc !== 12'h110) begin errors++; $display("FAIL branch15_inc got %h exp 110", pc); end
        $display("branch: pc=%h", pc);
    endtask

    task automatic test_priority();
        start = 1'b1;
        step();
        start = 1'b0;
        checks++; if (pc !== 12'h111) begin errors++; $display("FAIL start_in_run got %h exp 111", pc); end
        stall = 1'b1;
        do_branch(4'd7);
        stall = 1'b0;
        checks++; if (pc !== 12'h111) begin errors++; $display("FAIL stall_branch got %h exp 111", pc); end
        halt_req = 1'b1;
        stall = 1'b1;
        do_branch(4'd7);
        halt_req = 1'b0;
        stall = 1'b0;
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_halted got %b exp 1", halted); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL halt_running got %b exp 0", running); end
        checks++; if (pc !== 12'h111) begin errors++; $display("FAIL halt_pc got %h exp 111", pc); end
        step();
        checks++; if (pc !== 12'h111) begin errors++; $display("FAIL halt_hold_pc got %h exp 111", pc); end
        start = 1'b1;
        step();
        start = 1'b0;
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL restart_running got %b exp 1", running); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL restart_halted got %b exp 0", halted); end
        checks++; if (pc !== RST_PC) begin errors++; $display("FAIL restart_pc got %h exp %h", pc, RST_PC); end
        do_branch(4'd7);
        checks++; if (pc !== 12'h2A0) begin errors++; $display("FAIL retained7 got %h exp 2a0", pc); end
        $display("priority: pc=%h", pc);
    endtask

    task automatic test_reset_mid_run();
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (18) step();
        checks++; if (pc !== 12'h010) begin errors++; $display("FAIL run_to_010 got %h exp 010", pc); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL rst_run_cfg_ready got %b exp 1", cfg_ready); end
        checks++; if (pc !== RST_PC) begin errors++; $display("FAIL rst_run_pc got %h exp %h", pc, RST_PC); end
        checks++; if (lut_loaded !== 1'b0) begin errors++; $display("FAIL rst_run_lut_loaded got %b exp 0", lut_loaded); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL rst_run_running got %b exp 0", running); end
        $display("reset_mid_run: pc=%h", pc);
    endtask

    task automatic test_reset_mid_load();
        for (int i = 0; i < 9; i++) begin
            cfg_valid = 1'b1;
            cfg_data = 12'h300 + 12'(i);
            step();
        end
        cfg_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL rst_load_cfg_ready got %b exp 1", cfg_ready); end
        checks++; if (lut_loaded !== 1'b0) begin errors++; $display("FAIL rst_load_lut_loaded got %b exp 0", lut_loaded); end
        checks++; if (pc !== RST_PC) begin errors++; $display("FAIL rst_load_pc got %h exp %h", pc, RST_PC); end
        for (int i = 0; i < 16; i++) begin
            cfg_valid = 1'b1;
            cfg_data = 12'h400 + 12'(i);
            step();
        end
        cfg_valid = 1'b0;
        checks++; if (lut_loaded !== 1'b1) begin errors++; $display("FAIL reload_lut_loaded got %b exp 1", lut_loaded); end
        start = 1'b1;
        step();
        start = 1'b0;
        do_branch(4'd2);
        checks++; if (pc !== 12'h402) begin errors++; $display("FAIL reload_branch2 got %h exp 402", pc); end
        do_branch(4'd9);
        checks++; if (pc !== 12'h409) begin errors++; $display("FAIL reload_branch9 got %h exp 409", pc); end
        $display("reset_mid_load: pc=%h", pc);
    endtask

    initial begin
        reset = 1'b1;
        cfg_valid = 1'b0;
        cfg_data = '0;
        start = 1'b0;
        branch_taken = 1'b0;
        branch_index = '0;
        stall = 1'b0;
        halt_req = 1'b0;
        step();
        test_reset();
        test_load_gaps();
        test_sequential_wrap();
        test_branch();
        test_priority();
        test_reset_mid_run();
        test_reset_mid_load();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
